// File: rtl/rd_b_vec_infmap_pkg.sv
// Shared definitions for the FC-layer BRAM vector reader.
//   - FSM state codes S_IDLE/S_ISSUE/S_DRAIN/S_OUT
//   - derived-size helpers: BRAM depth and worst-case words per vector
// Element packing order, used on both sides of the reader: element c of a
// BRAM word sits at bits [c*I_F_BW +: I_F_BW], and element k of an output
// vector sits at bits [k*I_F_BW +: I_F_BW]. In both cases element 0 is the LSB.
package rd_b_vec_infmap_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } rd_state_e;

  // ceil(ich / col): number of BRAM words holding ich elements.
  function automatic int b_depth(input int ich, input int col);
    return (ich + col - 1) / col;
  endfunction

  // Worst-case words touched by one vector (start in the last column).
  function automatic int nw_max(input int ich_t, input int col);
    return (col - 1 + ich_t + col - 1) / col;
  endfunction

endpackage

// File: rtl/rd_b_vec_infmap_word_aligner.sv
// Word buffer and aligner. It collects up to NUM_SLOTS BRAM words, shifts out
// the leading column offset, and returns VEC_ELTS elements.
// Ports:
//   clk, areset      clock, synchronous active-high reset
//   clr_i            zero the buffer (start of a new vector)
//   wr_en_i          capture wr_data_i into slot wr_slot_i this cycle
//   wr_slot_i        destination slot index
//   wr_data_i        BRAM word
//   col_i            column of the first wanted element inside slot 0
//   vec_o            aligned vector. It already includes this cycle's write,
//                    so the caller can register it on the same edge as the
//                    last capture.
module rd_b_vec_infmap_word_aligner #(
  parameter int NUM_SLOTS = 4,
  parameter int B_COL_NUM = 4,
  parameter int I_F_BW    = 8,
  parameter int VEC_ELTS  = 10,
  parameter int SLOT_W    = 3,
  parameter int COL_W     = 2,
  localparam int B_DATA_W = B_COL_NUM * I_F_BW,
  localparam int VEC_W    = VEC_ELTS * I_F_BW
) (
  input  logic                clk,
  input  logic                areset,
  input  logic                clr_i,
  input  logic                wr_en_i,
  input  logic [SLOT_W-1:0]   wr_slot_i,
  input  logic [B_DATA_W-1:0] wr_data_i,
  input  logic [COL_W-1:0]    col_i,
  output logic [VEC_W-1:0]    vec_o
);

  logic [NUM_SLOTS-1:0][B_DATA_W-1:0] buf_q, buf_d;
  logic [NUM_SLOTS*B_DATA_W-1:0]      flat;

  always_comb begin
    buf_d = buf_q;
    for (int s = 0; s < NUM_SLOTS; s++)
      if (wr_en_i && wr_slot_i == SLOT_W'(s)) buf_d[s] = wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (areset || clr_i) buf_q <= '0;
    else                 buf_q <= buf_d;
  end

  // Slot 0 holds the lowest elements, so a right shift by the column offset
  // moves the first wanted element to bit 0.
  always_comb begin
    flat  = buf_d >> (32'(col_i) * I_F_BW);
    vec_o = flat[VEC_W-1:0];
  end

endmodule

// File: rtl/rd_b_vec_infmap.sv
// BRAM vector reader for FC layers. From a BRAM that packs B_COL_NUM elements
// per word, it reads ICH_T consecutive I_F_BW-bit elements starting at any
// element index, aligns them, and emits one packed vector with a valid/ready
// handshake.
// Ports:
//   clk, areset          clock, synchronous active-high reset
//   i_run                start pulse. It is accepted in S_IDLE or on the
//                        output-accept cycle; at any other time it sets o_en_err.
//   i_rd_start_idx       first element index
//   i_ot_ready           consumer ready
//   o_idle / o_run       FSM idle / busy
//   o_en_err             sticky error (ignored start, or illegal range)
//   o_ot_valid/o_ot_done vector valid (held until accepted) / accept pulse
//   o_ot_infmap          element k at bits [k*I_F_BW +: I_F_BW]
//   b_o_infmap_*         BRAM address / chip enable / write enable (always 0)
//   b_i_infmap_q         BRAM read data
// Build option RD_B_VEC_ZPAD_EN:
//   - defined: reads may run past ICH. Words beyond the last are not read,
//     and those elements are output as 0.
//   - undefined: a start with idx+ICH_T > ICH is rejected and flagged.
module rd_b_vec_infmap
  import rd_b_vec_infmap_pkg::*;
#(
  parameter int ICH       = 400,
  parameter int ICH_T     = 10,
  parameter int I_F_BW    = 8,
  parameter int B_COL_NUM = 4,
  parameter int B_RD_LAT  = 1,
  localparam int B_DATA_W = B_COL_NUM * I_F_BW,
  localparam int B_DEPTH  = b_depth(ICH, B_COL_NUM),
  localparam int B_ADDR_W = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1,
  localparam int IDX_BW   = (ICH > 1) ? $clog2(ICH) : 1,
  localparam int OUT_W    = ICH_T * I_F_BW
) (
  input  logic                clk,
  input  logic                areset,
  input  logic                i_run,
  input  logic [IDX_BW-1:0]   i_rd_start_idx,
  input  logic                i_ot_ready,
  output logic                o_idle,
  output logic                o_run,
  output logic                o_en_err,
  output logic                o_ot_valid,
  output logic                o_ot_done,
  output logic [OUT_W-1:0]    o_ot_infmap,
  output logic [B_ADDR_W-1:0] b_o_infmap_addr,
  output logic                b_o_infmap_ce,
  output logic                b_o_infmap_we,
  input  logic [B_DATA_W-1:0] b_i_infmap_q
);

  localparam int COL_W  = $clog2(B_COL_NUM);
  localparam int NW_MAX = nw_max(ICH_T, B_COL_NUM);
  localparam int NW_W   = $clog2(NW_MAX + 1);

  rd_state_e             state_q;
  logic [B_ADDR_W-1:0]   addr_q;
  logic                  ce_q;
  logic [NW_W-1:0]       wcnt_q, nw_q, nw_d;
  logic [1:0]            dcnt_q;
  logic [COL_W-1:0]      col_q;
  logic                  valid_q, err_q;
  logic [OUT_W-1:0]      infmap_q;
  logic [OUT_W-1:0]      vec_al, vec_out;

  // Capture strobe and slot number, delayed by the BRAM read latency.
  logic [B_RD_LAT:0]             vld_pipe;
  logic [B_RD_LAT-1:0]           vld_sr_q;
  logic [B_RD_LAT:0][NW_W-1:0]   slot_pipe;
  logic [B_RD_LAT-1:0][NW_W-1:0] slot_sr_q;

  logic accept, can_start, start_ok, start;

  assign accept    = valid_q & i_ot_ready;
  assign can_start = (state_q == S_IDLE) | accept;
`ifdef RD_B_VEC_ZPAD_EN
  assign start_ok  = 32'(i_rd_start_idx) < 32'(ICH);
`else
  assign start_ok  = (32'(i_rd_start_idx) + 32'(ICH_T)) <= 32'(ICH);
`endif
  assign start     = i_run & can_start & start_ok;
  assign nw_d      = NW_W'((32'(i_rd_start_idx[COL_W-1:0]) + 32'(ICH_T)
                            + 32'(B_COL_NUM) - 32'd1) >> COL_W);

  assign vld_pipe  = {vld_sr_q, ce_q};
  assign slot_pipe = {slot_sr_q, wcnt_q};

  always_ff @(posedge clk) begin
    if (areset) begin
      vld_sr_q  <= '0;
      slot_sr_q <= '0;
    end else begin
      vld_sr_q  <= vld_pipe[B_RD_LAT-1:0];
      slot_sr_q <= slot_pipe[B_RD_LAT-1:0];
    end
  end

  rd_b_vec_infmap_word_aligner #(
    .NUM_SLOTS(NW_MAX), .B_COL_NUM(B_COL_NUM), .I_F_BW(I_F_BW),
    .VEC_ELTS(ICH_T), .SLOT_W(NW_W), .COL_W(COL_W)
  ) u_align (
    .clk(clk), .areset(areset), .clr_i(start),
    .wr_en_i(vld_pipe[B_RD_LAT]), .wr_slot_i(slot_pipe[B_RD_LAT]),
    .wr_data_i(b_i_infmap_q), .col_i(col_q), .vec_o(vec_al)
  );

`ifdef RD_B_VEC_ZPAD_EN
  logic [IDX_BW-1:0] start_q;
  always_ff @(posedge clk) begin
    if (areset)     start_q <= '0;
    else if (start) start_q <= i_rd_start_idx;
  end
  // Elements past ICH come out as zero. This matters when the last BRAM word
  // is only partly populated.
  for (genvar k = 0; k < ICH_T; k++) begin : g_zmask
    assign vec_out[k*I_F_BW +: I_F_BW] = ((32'(start_q) + 32'(k)) < 32'(ICH))
                                         ? vec_al[k*I_F_BW +: I_F_BW] : '0;
  end
`else
  assign vec_out = vec_al;
`endif

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      ce_q     <= 1'b0;
      wcnt_q   <= '0;
      nw_q     <= '0;
      dcnt_q   <= '0;
      col_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      infmap_q <= '0;
    end else begin
      case (state_q)
        S_ISSUE: begin
          if (wcnt_q == nw_q - NW_W'(1)) begin
            state_q <= S_DRAIN;
            ce_q    <= 1'b0;
            dcnt_q  <= '0;
          end else begin
            wcnt_q <= wcnt_q + NW_W'(1);
            // Hold the address at the last word; later slots stay zero.
            if (addr_q == B_ADDR_W'(B_DEPTH - 1)) ce_q <= 1'b0;
            else                                 addr_q <= addr_q + B_ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (dcnt_q == 2'(B_RD_LAT - 1)) begin
            // The aligner output already includes the last word arriving now.
            state_q  <= S_OUT;
            valid_q  <= 1'b1;
            infmap_q <= vec_out;
          end else begin
            dcnt_q <= dcnt_q + 2'd1;
          end
        end
        S_OUT: begin
          if (accept) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase

      // A start (including back-to-back on accept) overrides the case above.
      if (start) begin
        state_q  <= S_ISSUE;
        addr_q   <= B_ADDR_W'(i_rd_start_idx >> COL_W);
        ce_q     <= 1'b1;
        wcnt_q   <= '0;
        nw_q     <= nw_d;
        col_q    <= i_rd_start_idx[COL_W-1:0];
        valid_q  <= 1'b0;
        infmap_q <= '0;
      end
      if (i_run && (!can_start || !start_ok)) err_q <= 1'b1;
    end
  end

  assign o_idle          = (state_q == S_IDLE);
  assign o_run           = ~o_idle;
  assign o_en_err        = err_q;
  assign o_ot_valid      = valid_q;
  assign o_ot_done       = accept;
  assign o_ot_infmap     = infmap_q;
  assign b_o_infmap_addr = addr_q;
  assign b_o_infmap_ce   = ce_q;
  assign b_o_infmap_we   = 1'b0;

endmodule

// File: tb/tb_rd_b_vec_infmap.sv
// Bench for rd_b_vec_infmap with its default parameters. The BRAM model holds
// element i = i mod 256. Expected addresses, latency and vectors are computed
// from the element-index arithmetic.
module tb_rd_b_vec_infmap;
  localparam int ICH = 400, ICH_T = 10, I_F_BW = 8, B_COL_NUM = 4, B_RD_LAT = 1;
  localparam int B_DEPTH = 100, B_ADDR_W = 7, IDX_BW = 9;
  localparam int B_DATA_W = B_COL_NUM * I_F_BW, OUT_W = ICH_T * I_F_BW;

  logic clk = 1'b0;
  logic areset, i_run, i_ot_ready;
  logic [IDX_BW-1:0]   i_rd_start_idx;
  logic o_idle, o_run, o_en_err, o_ot_valid, o_ot_done;
  logic [OUT_W-1:0]    o_ot_infmap;
  logic [B_ADDR_W-1:0] b_o_infmap_addr;
  logic b_o_infmap_ce, b_o_infmap_we;
  logic [B_DATA_W-1:0] b_i_infmap_q = '0;

  int total = 0, bad = 0;

  rd_b_vec_infmap dut (
    .clk(clk), .areset(areset), .i_run(i_run), .i_rd_start_idx(i_rd_start_idx),
    .i_ot_ready(i_ot_ready), .o_idle(o_idle), .o_run(o_run), .o_en_err(o_en_err),
    .o_ot_valid(o_ot_valid), .o_ot_done(o_ot_done), .o_ot_infmap(o_ot_infmap),
    .b_o_infmap_addr(b_o_infmap_addr), .b_o_infmap_ce(b_o_infmap_ce),
    .b_o_infmap_we(b_o_infmap_we), .b_i_infmap_q(b_i_infmap_q)
  );

  always #5 clk = ~clk;

  // BRAM with one cycle of read latency
  always @(posedge clk)
    if (b_o_infmap_ce)
      for (int c = 0; c < B_COL_NUM; c++)
        b_i_infmap_q[c*I_F_BW +: I_F_BW] <= 8'((int'(b_o_infmap_addr) * B_COL_NUM + c) % 256);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] ref_vec(input int idx);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int k = 0; k < ICH_T; k++)
      if (idx + k < ICH) v[k*I_F_BW +: I_F_BW] = 8'((idx + k) % 256);
    return v;
  endfunction

  task automatic launch(input int idx);
    i_rd_start_idx = IDX_BW'(idx);
    i_run = 1'b1;
    @(negedge clk);
    i_run = 1'b0;
  endtask

  // Called at the negedge of cycle 1. Returns at the negedge of the valid cycle.
  task automatic check_read(input int idx, input bit poke);
    int base, nw, cyc, a;
    base = idx / B_COL_NUM;
    nw   = (idx % B_COL_NUM + ICH_T + B_COL_NUM - 1) / B_COL_NUM;
    cyc  = 1;
    for (int w = 0; w < nw; w++) begin
      a = base + w;
      chk("issue_ce", b_o_infmap_ce, a < B_DEPTH);
      chk("issue_addr", b_o_infmap_addr, (a < B_DEPTH) ? a : B_DEPTH - 1);
      if (poke) begin
        i_run = (w == 0);
        i_rd_start_idx = 9'd7;
      end
      @(negedge clk); cyc++;
    end
    i_run = 1'b0;
    while (!o_ot_valid && cyc < 20) begin
      chk("drain_ce", b_o_infmap_ce, 0);
      @(negedge clk); cyc++;
    end
    chk("valid_cycle", cyc, nw + B_RD_LAT + 1);
    chk("vector", o_ot_infmap, ref_vec(idx));
    chk("done_while_not_ready", o_ot_done, 0);
  endtask

  task automatic stall(input int n, input int idx);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("stall_valid", o_ot_valid, 1);
      chk("stall_vector", o_ot_infmap, ref_vec(idx));
      chk("stall_ce", b_o_infmap_ce, 0);
      chk("stall_done", o_ot_done, 0);
    end
  endtask

  task automatic accept_vec(input bit chain, input int nidx);
    i_ot_ready = 1'b1;
    i_run = chain;
    i_rd_start_idx = IDX_BW'(nidx);
    #1;
    chk("done", o_ot_done, 1);
    @(negedge clk);
    i_ot_ready = 1'b0;
    i_run = 1'b0;
    chk("valid_dropped", o_ot_valid, 0);
    chk(chain ? "b2b_run" : "idle_after", chain ? o_run : o_idle, 1);
  endtask

  initial begin
    int idx, st;
    areset = 1'b1; i_run = 1'b0; i_ot_ready = 1'b0; i_rd_start_idx = '0;
    repeat (2) @(negedge clk);
    chk("rst_idle", o_idle, 1);
    chk("rst_run", o_run, 0);
    chk("rst_err", o_en_err, 0);
    chk("rst_valid", o_ot_valid, 0);
    chk("rst_done", o_ot_done, 0);
    chk("rst_vec", o_ot_infmap, 0);
    chk("rst_addr", b_o_infmap_addr, 0);
    chk("rst_ce", b_o_infmap_ce, 0);
    chk("rst_we", b_o_infmap_we, 0);
    areset = 1'b0;
    @(negedge clk);

    // aligned start, then a start in the last column
    launch(0);  check_read(0, 0);  accept_vec(0, 0);
    launch(3);  check_read(3, 0);  accept_vec(0, 0);

    // backpressure
    launch(21); check_read(21, 0); stall(10, 21); accept_vec(0, 0);

    // back-to-back with no bubble
    launch(40); check_read(40, 0); accept_vec(1, 50);
    check_read(50, 0); accept_vec(0, 0);
    chk("err_clean", o_en_err, 0);

    // i_run while issuing is ignored but flagged
    launch(100); check_read(100, 1);
    chk("err_sticky", o_en_err, 1);
    accept_vec(0, 0);

    // reset during drain
    launch(8);
    repeat (3) @(negedge clk);
    chk("mid_run", o_run, 1);
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    chk("abort_idle", o_idle, 1);
    chk("abort_err", o_en_err, 0);
    chk("abort_valid", o_ot_valid, 0);
    chk("abort_vec", o_ot_infmap, 0);
    chk("abort_ce", b_o_infmap_ce, 0);
    chk("abort_addr", b_o_infmap_addr, 0);
    repeat (6) @(negedge clk);
    chk("abort_no_valid", o_ot_valid, 0);

    // random in-range starts with random stalls
    for (int r = 0; r < 8; r++) begin
      idx = $urandom_range(0, ICH - ICH_T);
      st  = $urandom_range(0, 3);
      launch(idx); check_read(idx, 0);
      if (st > 0) stall(st, idx);
      accept_vec(0, 0);
    end

    // start past the end of the array
`ifdef RD_B_VEC_ZPAD_EN
    launch(395); check_read(395, 0); accept_vec(0, 0);
    chk("zpad_err", o_en_err, 0);
`else
    launch(395);
    chk("reject_idle", o_idle, 1);
    chk("reject_ce", b_o_infmap_ce, 0);
    chk("reject_err", o_en_err, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
